// File: rtl/rfft_unload.sv
// rfft_unload: streams the 256 RFFT results out in natural bin order.
// The core stores bin n at bank bitrev8(n)[7:6], address bitrev8(n)[5:0].
// This block reads the four banks in bitrev order and tags each read with its bank and bin index.
// Each returned word goes into a small show-ahead FIFO, and the FIFO absorbs sink backpressure.
// Reads are credit-limited so that the FIFO cannot overflow.
//
// Ports
//   Clk, Reset_n          clock, synchronous active-low reset
//   start                 1-cycle launch pulse; ignored while busy
//   busy                  high from the cycle after an accepted start through done
//   rd_en, rd_addr        read strobe and address shared by all four banks
//   ram_dout0..3          bank read data, valid RD_LAT cycles after rd_en
//   out_valid, out_ready  valid/ready handshake on the result stream
//   out_data, out_index   result word and its natural-order bin index
//   out_last              marks bin 255
//   done                  1-cycle pulse after the bin-255 transfer
module rfft_unload #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  output logic             busy,
  output logic             rd_en,
  output logic [5:0]       rd_addr,
  input  logic [WIDTH-1:0] ram_dout0,
  input  logic [WIDTH-1:0] ram_dout1,
  input  logic [WIDTH-1:0] ram_dout2,
  input  logic [WIDTH-1:0] ram_dout3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [7:0]       out_index,
  output logic             out_last,
  output logic             done
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  state_t           state;
  logic [7:0]       rd_cnt;
  logic [CNT_W-1:0] inflight;

  // Read-tracking pipe. Stage 0 lines up with rd_en, and stage RD_LAT lines up with ram_dout.
  logic             pipe_vld [RD_LAT+1];
  logic [1:0]       pipe_tag [RD_LAT+1];
  logic [7:0]       pipe_idx [RD_LAT+1];

  logic [WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [7:0]       fifo_idx  [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;

  logic             issue_c;
  logic [7:0]       rd_idx_c;
  logic [7:0]       rd_rev_c;
  logic             push_c;
  logic             pop_c;
  logic             last_pop_c;
  logic [WIDTH-1:0] push_data_c;
  logic [CNT_W-1:0] fifo_cnt_nxt_c;

  // Issue and handshake decisions.
  // The start edge issues read 0 directly, so first data arrives after RD_LAT+1 edges.
  always_comb begin
    issue_c    = 1'b0;
    rd_idx_c   = 8'd0;
    if (state == S_IDLE) begin
      issue_c  = start;
    end else if (state == S_RUN) begin
      rd_idx_c = rd_cnt;
      issue_c  = (32'(inflight) + 32'(fifo_cnt)) < FIFO_DEPTH;
    end
    rd_rev_c   = bitrev8(rd_idx_c);
    push_c     = pipe_vld[RD_LAT];
    pop_c      = out_valid & out_ready;
    last_pop_c = pop_c && (out_index == 8'hFF);
  end

  // Select the returning bank by its tag.
  always_comb begin
    push_data_c = ram_dout0;
    case (pipe_tag[RD_LAT])
      2'd0:    push_data_c = ram_dout0;
      2'd1:    push_data_c = ram_dout1;
      2'd2:    push_data_c = ram_dout2;
      default: push_data_c = ram_dout3;
    endcase
  end

  // Next FIFO occupancy. A simultaneous push and pop leaves it unchanged.
  always_comb begin
    fifo_cnt_nxt_c = fifo_cnt;
    if (push_c && !pop_c)      fifo_cnt_nxt_c = fifo_cnt + CNT_W'(1);
    else if (!push_c && pop_c) fifo_cnt_nxt_c = fifo_cnt - CNT_W'(1);
  end

  // Sequencing FSM.
  // rd_cnt holds the index of the next read. Read 0 is issued on the start edge.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state  <= S_IDLE;
      rd_cnt <= 8'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_RUN;
            rd_cnt <= 8'd1;
            busy   <= 1'b1;
          end
        end
        S_RUN: begin
          if (issue_c) begin
            rd_cnt <= rd_cnt + 8'd1;
            if (rd_cnt == 8'hFF) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((inflight == '0) && last_pop_c) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Read strobe, tag pipe, credit counter and output FIFO.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rd_en     <= 1'b0;
      rd_addr   <= 6'd0;
      inflight  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      out_valid <= 1'b0;
      for (int unsigned k = 0; k <= RD_LAT; k++) begin
        pipe_vld[k] <= 1'b0;
        pipe_tag[k] <= 2'd0;
        pipe_idx[k] <= 8'd0;
      end
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
        fifo_data[k] <= '0;
        fifo_idx[k]  <= 8'd0;
      end
    end else begin
      rd_en <= issue_c;
      if (issue_c) rd_addr <= rd_rev_c[5:0];

      pipe_vld[0] <= issue_c;
      pipe_tag[0] <= rd_rev_c[7:6];
      pipe_idx[0] <= rd_idx_c;
      for (int unsigned k = 1; k <= RD_LAT; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_tag[k] <= pipe_tag[k-1];
        pipe_idx[k] <= pipe_idx[k-1];
      end

      if (issue_c && !push_c)      inflight <= inflight + CNT_W'(1);
      else if (!issue_c && push_c) inflight <= inflight - CNT_W'(1);

      // Credit guarantees room, so the push needs no full check.
      if (push_c) begin
        fifo_data[wr_ptr] <= push_data_c;
        fifo_idx[wr_ptr]  <= pipe_idx[RD_LAT];
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt  <= fifo_cnt_nxt_c;
      out_valid <= (fifo_cnt_nxt_c != '0);
    end
  end

  // Show-ahead head. The head only moves on a transfer, so it is stable while stalled.
  assign out_data  = fifo_data[rd_ptr];
  assign out_index = fifo_idx[rd_ptr];
  assign out_last  = out_valid && (out_index == 8'hFF);

endmodule

// File: tb/tb_rfft_unload.sv
// Self-checking bench for rfft_unload.
// A behavioural bank model feeds the DUT, and a scoreboard queue holds the expected natural-order stream.
// A negedge monitor checks every transfer against that queue.
module tb_rfft_unload;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned RD_LAT     = 1;
  localparam int unsigned FIFO_DEPTH = 4;

  logic             Clk = 1'b0;
  logic             Reset_n = 1'b0;
  logic             start = 1'b0;
  logic             out_ready = 1'b0;
  logic             busy, rd_en, out_valid, out_last, done;
  logic [5:0]       rd_addr;
  logic [7:0]       out_index;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] dout0, dout1, dout2, dout3;

  rfft_unload #(.WIDTH(WIDTH), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .busy(busy),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .ram_dout0(dout0), .ram_dout1(dout1), .ram_dout2(dout2), .ram_dout3(dout3),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .done(done)
  );

  always #5 Clk = ~Clk;

  // Bank model with one cycle of read latency.
  logic [WIDTH-1:0] mem [0:3][0:63];
  always @(posedge Clk) begin
    if (rd_en) begin
      dout0 <= mem[0][rd_addr];
      dout1 <= mem[1][rd_addr];
      dout2 <= mem[2][rd_addr];
      dout3 <= mem[3][rd_addr];
    end
  end

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [7:0]       idx;
    logic             last;
  } exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int beats, done_cnt, issued, xfers, rdy_pct;
  bit pend_last, prev_stall, tag_mode;
  logic [WIDTH-1:0] prev_data;
  logic [7:0]       prev_idx;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int bitrev_ref(input int n);
    int r = 0;
    for (int i = 0; i < 8; i++) if (((n >> i) & 1) != 0) r |= (1 << (7 - i));
    return r;
  endfunction

  // Expected stream: bin n is the word the core stored at bitrev(n).
  task automatic load_expected();
    exp_t e;
    exp_q.delete();
    for (int n = 0; n < 256; n++) begin
      int r;
      r      = bitrev_ref(n);
      e.data = mem[r / 64][r % 64];
      e.idx  = 8'(n);
      e.last = (n == 255);
      exp_q.push_back(e);
    end
  endtask

  task automatic fill_mem(input bit tag_pattern);
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 64; a++)
        mem[b][a] = tag_pattern ? WIDTH'(b * 64 + a) : WIDTH'($urandom);
  endtask

  // Sink ready generator. It changes just after each rising edge.
  initial begin
    rdy_pct = 100;
    forever begin
      @(posedge Clk);
      #1 out_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // Monitor: scoreboard, stall stability, done timing and read credit.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (!Reset_n) begin
        prev_stall = 0; pend_last = 0; issued = 0; xfers = 0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_data", 64'(out_data), 64'(prev_data));
          check("stall_index", 64'(out_index), 64'(prev_idx));
        end
        if (pend_last || done) check("done_after_last", 64'(done), 64'(pend_last));
        pend_last = 0;
        if (done) done_cnt++;
        if (rd_en) begin
          issued++;
          check("read_credit", 64'((issued - xfers) <= int'(FIFO_DEPTH)), 64'd1);
        end
        if (out_valid && out_ready) begin
          xfers++;
          beats++;
          check("beat_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_index", 64'(out_index), 64'(e.idx));
            check("out_data", 64'(out_data), 64'(e.data));
            check("out_last", 64'(out_last), 64'(e.last));
            if (e.last) pend_last = 1;
          end
          if (tag_mode && out_index == 8'd1)   check("idx1_bank2_addr0", 64'(out_data), 64'd128);
          if (tag_mode && out_index == 8'd128) check("idx128_bank0_addr1", 64'(out_data), 64'd1);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_idx   = out_index;
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_rd_en"}, 64'(rd_en), 64'd0);
    check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_last"}, 64'(out_last), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_out_index"}, 64'(out_index), 64'd0);
    check({tag, "_out_data"}, 64'(out_data), 64'd0);
  endtask

  task automatic pulse_start();
    @(posedge Clk);
    #1 start = 1'b1;
    @(posedge Clk);
    #1 start = 1'b0;
  endtask

  // One full unload. Optionally spams start while busy and checks first-beat latency.
  task automatic run_stream(input bit spam, input bit check_lat);
    bit got;
    load_expected();
    beats = 0; done_cnt = 0;
    pulse_start();
    if (check_lat) begin
      @(negedge Clk);
      check("lat_busy", 64'(busy), 64'd1);
      check("lat_first_rd_en", 64'(rd_en), 64'd1);
      check("lat_first_rd_addr", 64'(rd_addr), 64'd0);
      check("lat_valid_e0", 64'(out_valid), 64'd0);
      @(negedge Clk);
      check("lat_valid_e1", 64'(out_valid), 64'd0);
      @(negedge Clk);
      check("lat_valid_e2", 64'(out_valid), 64'd1);
    end
    got = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge Clk);
      #1 start = spam && ($urandom_range(0, 3) == 0);
      @(negedge Clk);
      if (done) begin got = 1; break; end
    end
    start = 1'b0;
    check("done_seen", 64'(got), 64'd1);
    @(negedge Clk);
    check("busy_after_done", 64'(busy), 64'd0);
    check("done_count", 64'(done_cnt), 64'd1);
    check("beat_count", 64'(beats), 64'd256);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    tag_mode = 0;
    fill_mem(1'b1);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_reset_values("reset");
    #1 Reset_n = 1'b1;

    // Tag-pattern banks, sink always ready, latency check.
    tag_mode = 1; rdy_pct = 100;
    run_stream(1'b0, 1'b1);
    tag_mode = 0;

    // Random banks, sink ready about 30% of cycles.
    fill_mem(1'b0); rdy_pct = 30;
    run_stream(1'b0, 1'b0);

    // Random banks, repeated start pulses while busy.
    fill_mem(1'b0); rdy_pct = 50;
    run_stream(1'b1, 1'b0);

    // Reset in mid-stream, then a fresh run from index 0.
    fill_mem(1'b0); rdy_pct = 100;
    load_expected();
    beats = 0; done_cnt = 0;
    pulse_start();
    hit = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge Clk);
      if (beats >= 100) begin hit = 1; break; end
    end
    check("reached_beat_100", 64'(hit), 64'd1);
    @(posedge Clk);
    #1 Reset_n = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    check_reset_values("midreset");
    check("midreset_no_done", 64'(done_cnt), 64'd0);
    #1 Reset_n = 1'b1;
    exp_q.delete();
    fill_mem(1'b0);
    run_stream(1'b0, 1'b1);

    repeat (2) @(posedge Clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
